// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_MAX_HOLD = 8;

endpackage

// File: rtl/rr_sel.sv
// Combinational rotating-priority picker: first unmasked request at or above ptr,
// falling back to the lowest unmasked request when nothing sits at or above ptr.
module rr_sel #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic [NUM_REQ-1:0]         mask,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick;
    logic               found;

    always_comb begin
        cand  = req & ~mask;
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = cand[i] && (i >= int'(ptr));
        end
        pick = (|upper) ? upper : cand;

        // lowest set bit of the chosen half wins
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i] && !found) begin
                winner[i] = 1'b1;
                idx       = IW'(i);
                found     = 1'b1;
            end
        end
        any = |cand;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant hold while the owner
// keeps requesting, and bounded hold (MAX_HOLD) that forcibly moves the grant.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_valid,
    output logic                       req_up,
    output logic                       preempt,
    output arb_state_t                 dbg_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t         state_q, state_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [IW-1:0]      idx_q, idx_nxt;
    logic               valid_q, valid_nxt;
    logic               pre_q, pre_nxt;
    logic [IW-1:0]      ptr_q, ptr_nxt;
    logic [HW-1:0]      hold_q, hold_nxt;

    logic [NUM_REQ-1:0] sel_mask;
    logic [NUM_REQ-1:0] sel_winner;
    logic [IW-1:0]      sel_idx;
    logic               sel_any;
    logic               owner_req;
    logic               others;

    // The owner is masked out so a preemption can never re-pick it.
    assign sel_mask = (state_q == ARB_GRANT) ? gnt_q : '0;

    rr_sel #(.NUM_REQ(NUM_REQ)) u_sel (
        .req    (req),
        .ptr    (ptr_q),
        .mask   (sel_mask),
        .winner (sel_winner),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    assign owner_req = |(req & gnt_q);
    assign others    = |(req & ~gnt_q);

    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        idx_nxt   = idx_q;
        valid_nxt = valid_q;
        pre_nxt   = 1'b0;
        ptr_nxt   = ptr_q;
        hold_nxt  = hold_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (en && sel_any) begin
                    state_nxt = ARB_GRANT;
                    gnt_nxt   = sel_winner;
                    idx_nxt   = sel_idx;
                    valid_nxt = 1'b1;
                    ptr_nxt   = sel_idx + IW'(1);
                    hold_nxt  = '0;
                end
            end
            ARB_GRANT: begin
                if (!en || (!owner_req && !sel_any)) begin
                    state_nxt = ARB_IDLE;
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                end else if (!owner_req) begin
                    // release hands over in the same edge, no idle bubble
                    gnt_nxt  = sel_winner;
                    idx_nxt  = sel_idx;
                    ptr_nxt  = sel_idx + IW'(1);
                    hold_nxt = '0;
                end else if (others) begin
                    if (hold_q == HOLD_LAST) begin
                        gnt_nxt  = sel_winner;
                        idx_nxt  = sel_idx;
                        ptr_nxt  = sel_idx + IW'(1);
                        hold_nxt = '0;
                        pre_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
            idx_q   <= idx_nxt;
            valid_q <= valid_nxt;
            pre_q   <= pre_nxt;
            ptr_q   <= ptr_nxt;
            hold_q  <= hold_nxt;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = pre_q;
    assign req_up    = |req;
    assign dbg_state = state_q;

endmodule
